// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, LSB first, one bit per clock through one full adder cell
// Contains the 1-bit full adder cell and the serial_adder top.

module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  // Counter must be able to hold WIDTH itself so it never wraps on the last bit.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) + 1 : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic             fa_s;
  logic             fa_c;

  fulladder u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_c)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  assign res_next = (res_sr >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      ready  <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      cnt    <= '0;
      carry  <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (ready && start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
            state <= RUN;
            ready <= 1'b0;
          end else begin
            ready <= 1'b1;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          carry  <= fa_c;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
            sum   <= res_next;
            cout  <= fa_c;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder (WIDTH=8 and WIDTH=1)

module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, cin8, ready8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start1, cin1, ready1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .ready(ready8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .ready(ready1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with ready8=1; checks latency, result and return to idle.
  task automatic run_op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic cv, input logic [7:0] es, input logic ec);
    int n;
    check({tag, "_ready_before"}, ready8, 1);
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check({tag, "_ready_fell"}, ready8, 0);
    n = 0;
    while (!done8 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 8);
    check({tag, "_sum"}, sum8, es);
    check({tag, "_cout"}, cout8, ec);
    @(negedge clk);
    check({tag, "_done_pulse"}, done8, 0);
    check({tag, "_ready_after"}, ready8, 1);
  endtask

  task automatic wait_ready8(input string tag);
    int n;
    n = 0;
    while (!ready8 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_wait_ready"}, ready8, 1);
  endtask

  initial begin
    int n, dcnt, prev, rcnt;
    logic [7:0] cap;
    logic [1:0] res1;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (3) @(negedge clk);
    start8 = 1'b1;
    @(negedge clk);
    check("rst_ready", ready8, 0);
    check("rst_done", done8, 0);
    check("rst_sum", sum8, 0);
    check("rst_cout", cout8, 0);
    start8 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", ready8, 1);

    run_op8("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    run_op8("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op8("a5_5a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
    run_op8("3c_0f", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);

    // start pulses and operand changes during RUN are ignored
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    dcnt = 0; cap = 8'h00;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) begin start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; end
      if (i == 3) start8 = 1'b0;
      if (i == 5) start8 = 1'b1;
      if (i == 6) start8 = 1'b0;
      if (done8) begin dcnt++; cap = sum8; end
      @(negedge clk);
    end
    check("ign_done_count", dcnt, 1);
    check("ign_sum", cap, 8'h46);
    check("ign_ready_idle", ready8, 1);

    // continuous start: one operation every WIDTH+2 cycles
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    dcnt = 0; prev = -1; rcnt = 0;
    for (int i = 0; i < 45; i++) begin
      if (done8) begin
        if (prev >= 0) begin
          check("bb_gap", i - prev, 10);
          check("bb_ready_one", rcnt, 1);
        end
        check("bb_sum", sum8, 8'h30);
        prev = i; rcnt = 0; dcnt++;
      end
      if (ready8) rcnt++;
      @(negedge clk);
    end
    check("bb_done_count", dcnt, 4);
    start8 = 1'b0;
    wait_ready8("bb");

    // reset in the middle of RUN aborts the operation
    a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_ready", ready8, 0);
    check("abort_sum", sum8, 0);
    check("abort_cout", cout8, 0);
    @(negedge clk);
    check("abort_ready_rel", ready8, 1);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8) dcnt++;
      @(negedge clk);
    end
    check("abort_no_done", dcnt, 0);
    check("abort_sum_hold", sum8, 0);
    run_op8("post_abort", 8'h77, 8'h11, 1'b0, 8'h88, 1'b0);

    // WIDTH=1 exhaustive
    for (int v = 0; v < 8; v++) begin
      check("w1_ready", ready1, 1);
      a1 = v[0]; b1 = v[1]; cin1 = v[2]; start1 = 1'b1;
      res1 = 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
      @(negedge clk);
      start1 = 1'b0;
      n = 0;
      while (!done1 && n < 10) begin
        @(negedge clk);
        n++;
      end
      check("w1_latency", n, 1);
      check("w1_result", {cout1, sum1}, res1);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal values are 1 to 32.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, a synchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit, the operation request; it is sampled only while ready=1.
REQ-005 The block SHALL have port a, input, WIDTH bits, operand A; it is captured when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits, operand B; it is captured when start is accepted.
REQ-007 The block SHALL have port cin, input, 1 bit, the carry-in to bit 0; it is captured when start is accepted.
REQ-008 The block SHALL have port ready, output, 1 bit, high when the block can accept start.
REQ-009 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking that sum and cout are newly valid.
REQ-010 The block SHALL have port sum, output, WIDTH bits, the registered result, A+B+cin modulo 2^WIDTH.
REQ-011 The block SHALL have port cout, output, 1 bit, the registered carry out of bit WIDTH-1.

Function
REQ-012 The block SHALL compute the sum bit-serially, LSB first, one bit per clock, through exactly one instance of the codebase 1-bit full adder cell (fulladder), using no WIDTH-bit adder.
REQ-013 The block SHALL implement an FSM with three states:
- IDLE: ready=1.
- RUN: ready=0.
- DONE: ready=0, done=1.
REQ-014 In IDLE, start=1 at a rising edge SHALL accept an operation at that edge:
- capture a and b into shift registers;
- load the carry register with cin;
- clear the bit counter;
- go to RUN.
REQ-015 At each rising edge in RUN, the block SHALL:
- present operand bit i and the carry register to the full adder;
- shift the sum bit into the result shift register;
- load the carry register with the full adder carry;
- increment the counter.
REQ-016 After the edge that processes bit WIDTH-1, the block SHALL go to DONE, transfer the result shift register to sum, and load cout from the final carry.
REQ-017 Latency SHALL be fixed: with start accepted at edge k, done=1 in the cycle following edge k+WIDTH, so WIDTH cycles after acceptance.
REQ-018 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-019 Throughput SHALL be one operation per WIDTH+2 cycles; start held high continuously is accepted in every IDLE cycle.
REQ-020 start SHALL be ignored in RUN and DONE; it is neither queued nor counted.
REQ-021 Changes on a, b or cin after acceptance SHALL NOT affect the operation in flight.
REQ-022 sum and cout SHALL update only on entry to DONE and SHALL hold their values otherwise, including through subsequent RUN phases.
REQ-023 The bit counter SHALL be ceil(log2(WIDTH))+1 bits wide (1 bit when WIDTH=1) and SHALL NOT wrap within an operation.
REQ-024 With WIDTH=1, RUN SHALL last exactly one cycle.
REQ-025 All outputs SHALL be driven directly from registers or state decode, with no combinational path from inputs to outputs.

Reset
REQ-026 A rising edge with rst_n=0 SHALL set the following, regardless of start:
- state=IDLE;
- sum=0, cout=0, done=0;
- counter=0, carry register=0, shift registers=0.
REQ-027 Reset asserted during RUN or DONE SHALL abort the operation with no done pulse and no update of sum or cout beyond the reset values.
REQ-028 While rst_n=0, ready SHALL read 0; ready SHALL read 1 in the first cycle after the first edge with rst_n=1.

Verification (WIDTH=8 unless stated)
REQ-029 The bench SHALL apply a=0x00, b=0x00, cin=0 with start -> ready falls; done=1 exactly 8 cycles after acceptance; sum=0x00, cout=0.
REQ-030 The bench SHALL apply a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. It SHALL then apply a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1. It SHALL then apply a=0x3C, b=0x0F, cin=0 -> sum=0x4B, cout=0.
REQ-031 The bench SHALL pulse start again at cycles 2 and 5 of RUN and change a and b mid-RUN -> a single done with the original result; no second operation starts.
REQ-032 The bench SHALL hold start=1 continuously with fixed operands -> done pulses every 10 cycles; ready=1 for exactly one cycle between operations.
REQ-033 The bench SHALL apply rst_n=0 for one edge at cycle 4 of RUN -> no done; sum=0, cout=0; ready=1 after release; the next operation completes correctly.
REQ-034 The bench SHALL run WIDTH=1 exhaustively over all 8 (a,b,cin) combinations -> done one cycle after acceptance; {cout,sum} equals the full-adder truth table.
